gba_bus_reader: RTL
===================

Name: gba_bus_reader

Overview:
- Parametrised cartridge-bus read engine; next generation of the single-mode ROM dump FSM.
- Reads a programmable address range [start_addr, end_addr] from a GBA cartridge in ROM mode (16-bit, latched address) or SRAM mode (8-bit, direct address, CS2).
- Captured words are presented on a valid/ready stream with backpressure; cart strobes are stretched until the consumer accepts.
- Timing per bus phase is parametrised; the address is re-latched automatically at every 64K-word boundary in ROM mode.

Parameters:
- T_SETUP, 4, cycles address is driven before chip select falls (≥1)
- T_LATCH, 4, cycles n_cs low with address still driven (ROM) (≥1)
- T_RDLOW, 4, cycles n_rd low before capture (≥1)
- T_RDHIGH, 4, minimum cycles n_rd high between reads (≥1)
- CNT_W, 8, phase timer width; every T_* must be < 2^CNT_W

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level; sampled in IDLE
- abort  in  1  terminate the current transfer
- mode  in  1  0 = ROM, 1 = SRAM; sampled at start
- start_addr  in  24  first transfer address (ROM: halfword units; SRAM: byte address, low 16 bits used)
- end_addr  in  24  last transfer address, inclusive
- ad_in  in  16  cart AD0-15 input
- hi_in  in  8  cart A16-23/D0-7 input
- ad_out  out  16  AD0-15 drive value
- ad_oe  out  1  AD0-15 output enable
- hi_out  out  8  A16-23 drive value
- hi_oe  out  1  A16-23 output enable
- n_rd, n_wr, n_cs, n_cs2  out  1 each  cart strobes, active-low
- data_out  out  16  captured word (SRAM: {8'h00, byte})
- data_valid  out  1  data_out is valid
- data_ready  in  1  consumer accepts when data_valid & data_ready
- cur_addr  out  24  current transfer address
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE

Behaviour:
- Reset (sync, priority over everything): state IDLE; timer 0; cur_addr 0; data_valid 0; data_out 0; all strobes 1; ad_oe and hi_oe 0; ad_out and hi_out 0; busy and done 0.
- Phase timer: clears on every state change, else increments. A timed state exits when t == T_x-1, so it lasts exactly T_x cycles.
- States:
  - IDLE: if start=1, latch mode, load cur_addr=start_addr. If end_addr < start_addr go to DONE with no strobes; otherwise go to SETUP.
  - SETUP:
    - ROM: ad_oe=1, hi_oe=1, ad_out=cur_addr[15:0], hi_out=cur_addr[23:16], n_cs=1.
    - SRAM: ad_oe=1, hi_oe=0, n_cs2=0.
    - After T_SETUP: ROM goes to LATCH; SRAM goes to RD_LOW.
  - LATCH (ROM only): n_cs=0, address still driven; after T_LATCH go to TURN.
  - TURN (ROM only): 1 cycle; n_cs=0, ad_oe=0, hi_oe=0; go to RD_LOW.
  - RD_LOW: n_rd=0, chip select held. After T_RDLOW go to CAPTURE.
  - CAPTURE: 1 cycle, n_rd=0. Register data_out (ROM: ad_in; SRAM: {8'h00, hi_in}), set data_valid=1, go to RD_HIGH.
  - RD_HIGH: n_rd=1, chip select held. Exit only when t ≥ T_RDHIGH-1 AND the output slot is empty (data_valid=0, or accepted this cycle). The timer saturates while waiting.
    - If cur_addr == end_addr: go to DONE.
    - Otherwise cur_addr += 1, then:
      - ROM, new cur_addr[15:0] == 0: go to SETUP (n_cs=1; re-latch).
      - ROM, otherwise: go to RD_LOW (sequential read).
      - SRAM: go to SETUP.
  - DONE: all strobes 1, output enables 0, done=1. Go to IDLE when start=0. data_valid still drains normally.
- data_valid clears on the cycle after data_valid & data_ready; data_out is stable while valid.
- n_wr is always 1. n_cs2 is always 1 in ROM mode. n_cs is always 1 in SRAM mode.
- abort=1 in any busy state: next cycle is IDLE, strobes 1, output enables 0, data_valid 0. abort in IDLE or DONE has no effect.
- 24-bit address arithmetic: end_addr = 24'hFFFFFF terminates without wrap.
- start_addr == end_addr yields exactly one transfer.

Optional Feature:
- Macro: GBA_BUS_READER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[15:0]: modulo-2^16 sum of every data_out at capture. Cleared when leaving IDLE on start.
  - Adds output checksum_valid, high in DONE.
- Undefined: both ports absent; no checksum logic.

Test Plan:
- ROM, T_*=2, start=0x000010, end=0x000012, data_ready=1, ad_in=cur_addr^16'hA5A5 -> three valid words 0xA5B5, 0xA5B4, 0xA5B7. Exactly one n_cs falling edge. n_rd low for 3 cycles (RD_LOW+CAPTURE) each. done after the third word.
- ROM, start=0x00FFFE, end=0x010001 -> four words; n_cs returns high for T_SETUP cycles before 0x010000 and re-latches with hi_out=0x01, ad_out=0x0000.
- SRAM, start=0x0100, end=0x0103, hi_in=cur_addr[7:0] -> data 0x0000..0x0003; n_cs2 low, n_cs high, hi_oe=0 throughout; SETUP precedes every byte.
- Backpressure: data_ready=0 for 20 cycles after first capture -> FSM stays in RD_HIGH with n_rd=1, no second n_rd fall. Resume within T_RDHIGH after data_ready=1.
- abort asserted during second RD_LOW; separately, reset asserted mid-burst -> both give IDLE next cycle with all strobes 1, ad_oe=0, data_valid=0. Restart works.
- end_addr=0x000005 < start_addr=0x000009 -> DONE directly with no strobe activity; with GBA_BUS_READER_CHECKSUM_EN, checksum=0 and checksum_valid=1.

Source files
------------

// File: rtl/gba_bus_reader.sv
// GBA cartridge read engine: streams [start_addr, end_addr] in ROM (latched) or SRAM (direct) mode.
// Define GBA_BUS_READER_CHECKSUM_EN to add a 16-bit running checksum of captured words.
module gba_bus_reader #(
    parameter int unsigned T_SETUP  = 4,
    parameter int unsigned T_LATCH  = 4,
    parameter int unsigned T_RDLOW  = 4,
    parameter int unsigned T_RDHIGH = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        mode,
    input  logic [23:0] start_addr,
    input  logic [23:0] end_addr,
    input  logic [15:0] ad_in,
    input  logic [7:0]  hi_in,
    output logic [15:0] ad_out,
    output logic        ad_oe,
    output logic [7:0]  hi_out,
    output logic        hi_oe,
    output logic        n_rd,
    output logic        n_wr,
    output logic        n_cs,
    output logic        n_cs2,
    output logic [15:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic [23:0] cur_addr,
    output logic        busy,
`ifdef GBA_BUS_READER_CHECKSUM_EN
    output logic [15:0] checksum,
    output logic        checksum_valid,
`endif
    output logic        done
);

    typedef enum logic [2:0] {
        StIdle, StSetup, StLatch, StTurn, StRdLow, StCapture, StRdHigh, StDone
    } state_e;

    localparam logic [CNT_W-1:0] SetupLast  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LatchLast  = CNT_W'(T_LATCH - 1);
    localparam logic [CNT_W-1:0] RdLowLast  = CNT_W'(T_RDLOW - 1);
    localparam logic [CNT_W-1:0] RdHighLast = CNT_W'(T_RDHIGH - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  t_q;
    logic              mode_q;
    logic [23:0]       addr_q;
    logic [15:0]       data_q;
    logic              valid_q;

    logic              is_busy;
    logic              rdhigh_done;
    logic              at_end;
    logic [23:0]       addr_inc;
    logic [15:0]       capture_word;

    assign is_busy      = (state_q != StIdle) && (state_q != StDone);
    // Slot counts as empty when the pending word is being accepted this cycle.
    assign rdhigh_done  = (t_q >= RdHighLast) && (!valid_q || data_ready);
    assign at_end       = (addr_q == end_addr);
    assign addr_inc     = addr_q + 24'd1;
    assign capture_word = mode_q ? {8'h00, hi_in} : ad_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = (end_addr < start_addr) ? StDone : StSetup;
            end
            StSetup: begin
                if (t_q == SetupLast) state_d = mode_q ? StRdLow : StLatch;
            end
            StLatch: begin
                if (t_q == LatchLast) state_d = StTurn;
            end
            StTurn:    state_d = StRdLow;
            StRdLow: begin
                if (t_q == RdLowLast) state_d = StCapture;
            end
            StCapture: state_d = StRdHigh;
            StRdHigh: begin
                if (rdhigh_done) begin
                    if (at_end) begin
                        state_d = StDone;
                    end else if (mode_q || addr_inc[15:0] == 16'h0000) begin
                        // SRAM always re-enters SETUP; ROM re-latches at each 64K-word boundary
                        state_d = StSetup;
                    end else begin
                        state_d = StRdLow;
                    end
                end
            end
            StDone: begin
                if (!start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (abort && is_busy) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_q     <= '0;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                t_q <= '0;
            end else if (!(state_q == StRdHigh && t_q >= RdHighLast)) begin
                t_q <= t_q + 1'b1;
            end

            if (state_q == StIdle && start) begin
                mode_q <= mode;
                addr_q <= start_addr;
            end else if (state_q == StRdHigh && rdhigh_done && !at_end && !abort) begin
                addr_q <= addr_inc;
            end

            if (abort && is_busy) begin
                valid_q <= 1'b0;
            end else if (state_q == StCapture) begin
                valid_q <= 1'b1;
                data_q  <= capture_word;
            end else if (valid_q && data_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        n_rd   = 1'b1;
        n_wr   = 1'b1;
        n_cs   = 1'b1;
        n_cs2  = 1'b1;
        ad_oe  = 1'b0;
        hi_oe  = 1'b0;
        ad_out = '0;
        hi_out = '0;
        case (state_q)
            StSetup, StLatch: begin
                ad_oe  = 1'b1;
                ad_out = addr_q[15:0];
                if (mode_q) begin
                    n_cs2 = 1'b0;
                end else begin
                    hi_oe  = 1'b1;
                    hi_out = addr_q[23:16];
                    n_cs   = (state_q == StSetup);
                end
            end
            StTurn: n_cs = 1'b0;
            StRdLow, StCapture, StRdHigh: begin
                n_rd = (state_q == StRdHigh);
                if (mode_q) begin
                    n_cs2  = 1'b0;
                    ad_oe  = 1'b1;
                    ad_out = addr_q[15:0];
                end else begin
                    n_cs = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign busy       = is_busy;
    assign done       = (state_q == StDone);
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign cur_addr   = addr_q;

`ifdef GBA_BUS_READER_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else if (state_q == StIdle && start) begin
            sum_q <= '0;
        end else if (state_q == StCapture && !abort) begin
            sum_q <= sum_q + capture_word;
        end
    end

    assign checksum       = sum_q;
    assign checksum_valid = (state_q == StDone);
`endif

endmodule
